// File: rtl/hc4511_scan_ctrl.sv
// Scan controller that time-multiplexes one HC_4511 BCD-to-7-segment decoder
// across DIGITS common-cathode digits. Blanking gaps between digits suppress
// ghosting; a timed lamp test and leading-zero suppression are supported.
module hc4511_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 2,
    parameter int LT_CYC    = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  load,
    input  logic                  lz_en,
    input  logic                  lt_req,
    output logic [3:0]            A,
    output logic                  LT_N,
    output logic                  BI_N,
    output logic                  LE,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  busy
);

    localparam int MAX_SB = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int MAX_C  = (LT_CYC > MAX_SB) ? LT_CYC : MAX_SB;
    localparam int CNT_W  = $clog2(MAX_C + 1);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] LT_LAST    = CNT_W'(LT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] SEL_ONE   = {{(DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_LAMP, S_BLANK, S_SHOW} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_q, pend_d;
    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [3:0]          a_q, a_d;
    logic                lt_n_q, lt_n_d;
    logic                bi_n_q, bi_n_d;
    logic                le_q, le_d;
    logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic                busy_q, busy_d;
    logic                suppress;

    // Next-state sequencing: enable beats lamp request beats the scan timers.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = load ? bcd_in : pend_q;
        shadow_d = shadow_q;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else if (lt_req) begin
            state_d = S_LAMP;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                S_LAMP: begin
                    if (cnt_q == LT_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = S_SHOW;
                        cnt_d   = '0;
                        // Latch a whole frame only at the start of digit 0 so
                        // one scan never mixes digits from two frames.
                        if (idx_q == '0) shadow_d = pend_d;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so every output flips on one edge.
    always_comb begin
        a_d       = 4'd0;
        lt_n_d    = 1'b1;
        bi_n_d    = 1'b0;
        le_d      = 1'b1;
        dig_sel_d = '0;
        busy_d    = 1'b0;
        suppress  = 1'b0;
        if (lz_en && idx_d != '0) begin
            suppress = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= int'(idx_d) && shadow_d[4*i +: 4] != 4'd0) suppress = 1'b0;
            end
        end
        case (state_d)
            S_LAMP: begin
                lt_n_d    = 1'b0;
                bi_n_d    = 1'b1;
                le_d      = 1'b0;
                dig_sel_d = '1;
                busy_d    = 1'b1;
            end
            S_BLANK: begin
                busy_d = 1'b1;
            end
            S_SHOW: begin
                busy_d    = 1'b1;
                le_d      = 1'b0;
                dig_sel_d = SEL_ONE << idx_d;
                bi_n_d    = ~suppress;
                a_d       = suppress ? 4'd0 : shadow_d[{idx_d, 2'b00} +: 4];
            end
            default: ;
        endcase
    end

    // State, buffers and registered decoder outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            pend_q    <= '0;
            shadow_q  <= '0;
            a_q       <= 4'd0;
            lt_n_q    <= 1'b1;
            bi_n_q    <= 1'b0;
            le_q      <= 1'b1;
            dig_sel_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            pend_q    <= pend_d;
            shadow_q  <= shadow_d;
            a_q       <= a_d;
            lt_n_q    <= lt_n_d;
            bi_n_q    <= bi_n_d;
            le_q      <= le_d;
            dig_sel_q <= dig_sel_d;
            busy_q    <= busy_d;
        end
    end

    assign A       = a_q;
    assign LT_N    = lt_n_q;
    assign BI_N    = bi_n_q;
    assign LE      = le_q;
    assign dig_sel = dig_sel_q;
    assign busy    = busy_q;

endmodule
